// File: rtl/fa_bist_checker.sv
// Self-test engine for a full adder: sweeps all {A,B,Cin} vectors, checks S/Cout.
// Optional FA_BIST_STOP_ON_FAIL_EN ends the run on the first mismatch.
module fa_bist_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned PASSES        = 1,
   parameter int unsigned ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             A,
   output logic             B,
   output logic             Cin,
   input  logic             S,
   input  logic             Cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [2:0]       first_fail_vec
);

   localparam int unsigned SET_W  = 4;
   localparam int unsigned PASS_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

   logic [1:0]        r_state,    w_state;
   logic [2:0]        r_vec,      w_vec;
   logic [SET_W-1:0]  r_settle,   w_settle;
   logic [PASS_W-1:0] r_pass_cnt, w_pass_cnt;
   logic              r_busy,     w_busy;
   logic              r_done,     w_done;
   logic              r_pass,     w_pass;
   logic [ERR_W-1:0]  r_err,      w_err;
   logic              r_fail_vld, w_fail_vld;
   logic [2:0]        r_ffv,      w_ffv;

   logic w_exp_s;
   logic w_exp_c;
   logic w_cmp;
   logic w_mis;
   logic w_finish;

   // Golden full-adder function of the vector currently driven
   assign w_exp_s = r_vec[2] ^ r_vec[1] ^ r_vec[0];
   assign w_exp_c = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
   assign w_cmp   = (r_state == ST_RUN) && (r_settle == SETTLE_LAST);
   assign w_mis   = w_cmp && ((S != w_exp_s) || (Cout != w_exp_c));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_vec      <= 3'd0;
         r_settle   <= '0;
         r_pass_cnt <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err      <= '0;
         r_fail_vld <= 1'b0;
         r_ffv      <= 3'd0;
      end else begin
         r_state    <= w_state;
         r_vec      <= w_vec;
         r_settle   <= w_settle;
         r_pass_cnt <= w_pass_cnt;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_pass     <= w_pass;
         r_err      <= w_err;
         r_fail_vld <= w_fail_vld;
         r_ffv      <= w_ffv;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_vec      = r_vec;
      w_settle   = r_settle;
      w_pass_cnt = r_pass_cnt;
      w_busy     = r_busy;
      w_done     = r_done;
      w_pass     = r_pass;
      w_err      = r_err;
      w_fail_vld = r_fail_vld;
      w_ffv      = r_ffv;
      w_finish   = 1'b0;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state    = ST_RUN;
               w_busy     = 1'b1;
               w_done     = 1'b0;
               w_pass     = 1'b0;
               w_err      = '0;
               w_fail_vld = 1'b0;
               w_ffv      = 3'd0;
               w_vec      = 3'd0;
               w_settle   = '0;
               w_pass_cnt = '0;
            end
         end
         ST_RUN: begin
            if (!w_cmp) begin
               w_settle = r_settle + SET_W'(1);
            end else begin
               w_settle = '0;
               if (w_mis) begin
                  if (r_err != ERR_MAX) w_err = r_err + ERR_W'(1);
                  if (!r_fail_vld) begin
                     w_fail_vld = 1'b1;
                     w_ffv      = r_vec;
                  end
               end
               w_vec = r_vec + 3'd1;
               if (r_vec == 3'd7) w_pass_cnt = r_pass_cnt + PASS_W'(1);
`ifdef FA_BIST_STOP_ON_FAIL_EN
               w_finish = ((r_vec == 3'd7) && (r_pass_cnt == PASS_LAST)) || w_mis;
`else
               w_finish = (r_vec == 3'd7) && (r_pass_cnt == PASS_LAST);
`endif
               if (w_finish) begin
                  w_state = ST_DONE;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
                  w_vec   = 3'd0;
                  w_pass  = (w_err == '0);
               end
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   assign A              = r_vec[2];
   assign B              = r_vec[1];
   assign Cin            = r_vec[0];
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err;
   assign fail_valid     = r_fail_vld;
   assign first_fail_vec = r_ffv;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Scoreboard bench for fa_bist_checker: golden, Cout stuck-at-0 and S-inverted adders.
module tb_fa_bist_checker;

   typedef struct packed {
      logic [3:0]  err;
      logic        fv;
      logic [2:0]  ffv;
      logic        pass;
      int unsigned done_cyc;
   } exp_t;

`ifdef FA_BIST_STOP_ON_FAIL_EN
   localparam int unsigned LAT_COUT = 9;
   localparam int unsigned LAT_SINV = 3;
   localparam logic [3:0]  ERR_COUT = 4'd1;
   localparam logic [3:0]  ERR_SINV = 4'd1;
`else
   localparam int unsigned LAT_COUT = 17;
   localparam int unsigned LAT_SINV = 33;
   localparam logic [3:0]  ERR_COUT = 4'd4;
   localparam logic [3:0]  ERR_SINV = 4'd15;
`endif
   localparam int unsigned LAT_GOLD = 17;

   logic clk = 1'b0;
   logic rst;
   logic start1, start2;
   int   mode1;
   int unsigned cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
   logic [3:0] err1;
   logic [2:0] ffv1;
   logic a2, b2, c2, s2, co2, busy2, done2, pass2, fv2;
   logic [3:0] err2;
   logic [2:0] ffv2;

   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Adder models: DUT1 golden or Cout stuck-at-0, DUT2 with inverted S
   assign s1  = a1 ^ b1 ^ c1;
   assign co1 = (mode1 == 1) ? 1'b0 : ((a1 & b1) | (a1 & c1) | (b1 & c1));
   assign s2  = ~(a2 ^ b2 ^ c2);
   assign co2 = (a2 & b2) | (a2 & c2) | (b2 & c2);

   fa_bist_checker u_dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(co1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .first_fail_vec(ffv1)
   );

   fa_bist_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .A(a2), .B(b2), .Cin(c2), .S(s2), .Cout(co2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_valid(fv2), .first_fail_vec(ffv2)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] err, input logic fv, input logic [2:0] ffv,
                               input logic ps, input int unsigned dc);
      exp_t e;
      e.err = err; e.fv = fv; e.ffv = ffv; e.pass = ps; e.done_cyc = dc;
      return e;
   endfunction

   // Monitors: a rising done presents a result to be scored
   logic prev1 = 1'b0, prev2 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done1 && !prev1) begin
         if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
         else begin
            e = q1.pop_front();
            chk("dut1_err_count", int'(err1), int'(e.err));
            chk("dut1_fail_valid", int'(fv1), int'(e.fv));
            chk("dut1_first_fail_vec", int'(ffv1), int'(e.ffv));
            chk("dut1_pass", int'(pass1), int'(e.pass));
            chk("dut1_busy_at_done", int'(busy1), 0);
            chk("dut1_done_cycle", int'(cyc), int'(e.done_cyc));
         end
      end
      if (done2 && !prev2) begin
         if (q2.size() == 0) chk("dut2_unexpected_done", 1, 0);
         else begin
            e = q2.pop_front();
            chk("dut2_err_count", int'(err2), int'(e.err));
            chk("dut2_fail_valid", int'(fv2), int'(e.fv));
            chk("dut2_first_fail_vec", int'(ffv2), int'(e.ffv));
            chk("dut2_pass", int'(pass2), int'(e.pass));
            chk("dut2_done_cycle", int'(cyc), int'(e.done_cyc));
         end
      end
      prev1 <= done1;
      prev2 <= done2;
   end

   task automatic wait_done1(input string nm);
      int n = 0;
      while (!done1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done1) chk(nm, 0, 1);
      @(negedge clk);
   endtask

   task automatic pulse1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic chk_idle1(input string nm);
      chk({nm, "_abc"}, int'({a1, b1, c1}), 0);
      chk({nm, "_busy"}, int'(busy1), 0);
      chk({nm, "_done"}, int'(done1), 0);
      chk({nm, "_pass"}, int'(pass1), 0);
      chk({nm, "_err"}, int'(err1), 0);
      chk({nm, "_fv"}, int'(fv1), 0);
      chk({nm, "_ffv"}, int'(ffv1), 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode1 = 0;
      repeat (3) @(negedge clk);
      chk_idle1("reset");
      chk("reset_dut2_busy_done", int'({busy2, done2}), 0);
      rst = 1'b0;
      @(negedge clk);

      // S inverted, two passes: counter saturates
      q2.push_back(mk(ERR_SINV, 1'b1, 3'd0, 1'b0, cyc + LAT_SINV));
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done2) chk("dut2_timeout", 0, 1);
      @(negedge clk);

      // Golden run with vector order check
      q1.push_back(mk(4'd0, 1'b0, 3'd0, 1'b1, cyc + LAT_GOLD));
      pulse1();
      for (int i = 0; i < 16; i++) begin
         chk("golden_vec", int'({a1, b1, c1}), i / 2);
         chk("golden_busy", int'(busy1), 1);
         @(negedge clk);
      end
      chk("golden_done", int'(done1), 1);
      @(negedge clk);
      chk("done_abc_zero", int'({a1, b1, c1}), 0);

      // Cout stuck-at-0: vectors 3,5,6,7 fail
      mode1 = 1;
      q1.push_back(mk(ERR_COUT, 1'b1, 3'd3, 1'b0, cyc + LAT_COUT));
      pulse1();
      wait_done1("cout_timeout");
      repeat (3) @(negedge clk);
      chk("done_hold_err", int'(err1), int'(ERR_COUT));
      chk("done_hold_ffv", int'(ffv1), 3);

      // Restart from DONE clears results on the next cycle
      mode1 = 0;
      q1.push_back(mk(4'd0, 1'b0, 3'd0, 1'b1, cyc + LAT_GOLD));
      pulse1();
      chk("restart_done_drop", int'(done1), 0);
      chk("restart_err_clr", int'(err1), 0);
      chk("restart_fv_clr", int'(fv1), 0);
      chk("restart_busy", int'(busy1), 1);
      wait_done1("restart_timeout");

      // start during RUN is ignored; done time unchanged
      q1.push_back(mk(4'd0, 1'b0, 3'd0, 1'b1, cyc + LAT_GOLD));
      pulse1();
      repeat (5) @(negedge clk);
      pulse1();
      wait_done1("midstart_timeout");

      // Reset while vector 4 is driven
      pulse1();
      repeat (8) @(negedge clk);
      chk("pre_reset_vec", int'({a1, b1, c1}), 4);
      rst = 1'b1;
      #1;
      chk_idle1("midrun_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_idle1("post_reset");
      q1.push_back(mk(4'd0, 1'b0, 3'd0, 1'b1, cyc + LAT_GOLD));
      pulse1();
      wait_done1("post_reset_timeout");

      repeat (3) @(negedge clk);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fa_bist_checker.md
Name: fa_bist_checker

Overview:
- Hardware stimulus/response engine for the half-adder-built full adder (ports A, B, Cin -> S, Cout).
- Sits on the opposite side of the full-adder interface: drives all 8 input combinations on chip, samples the adder's outputs and checks them against the golden full-adder function.
- Reports pass/fail, a saturating error count and the first failing vector.
- Used as a power-on/self-test wrapper around full-adder instances.

Parameters:
- SETTLE_CYCLES, 2, clocks each vector is held before S/Cout are sampled; legal range 1..15.
- PASSES, 1, number of complete 8-vector sweeps per run; legal range 1..255.
- ERR_W, 4, width of err_count; the count saturates at 2^ERR_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE or DONE.
- A  out  1  operand A to the adder (registered).
- B  out  1  operand B to the adder (registered).
- Cin  out  1  carry-in to the adder (registered).
- S  in  1  sum returned by the adder.
- Cout  in  1  carry-out returned by the adder.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start.
- pass  out  1  valid while done=1; high iff err_count==0.
- err_count  out  ERR_W  number of mismatching samples, saturating.
- fail_valid  out  1  high once any mismatch has been captured.
- first_fail_vec  out  3  {A,B,Cin} of the first mismatch.

Behaviour:
- Reset (async): A=B=Cin=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, FSM=IDLE, vector/settle/pass counters=0.
- Reset mid-run: everything returns to the reset values immediately; no partial result is retained.
- FSM has three states: IDLE, RUN, DONE.
- IDLE/DONE with start=1: at the next edge go to RUN; busy=1, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, vec=0 driven ({A,B,Cin}=3'b000), settle=0, pass counter=0.
- RUN, settle counter:
  - settle increments each cycle.
  - When settle==SETTLE_CYCLES-1, the edge compares S/Cout against the expected values.
  - Expected S = A^B^Cin. Expected Cout = (A&B)|(A&Cin)|(B&Cin).
  - A mismatch is either output differing.
- On each mismatch:
  - err_count increments, holding at its maximum once saturated.
  - If fail_valid=0, capture first_fail_vec={A,B,Cin} and set fail_valid=1.
- Same compare edge: vec increments (wrapping 7->0 and incrementing the pass counter) and settle clears.
- Vector order is binary 0..7 with {A,B,Cin} = vec[2:0].
- Each vector occupies exactly SETTLE_CYCLES clocks, so one run lasts 8*SETTLE_CYCLES*PASSES clocks.
- Compare of vec 7 on the last pass: go to DONE, busy=0, done=1, pass=(final err_count==0). A/B/Cin return to 0.
- start while in RUN is ignored.
- start in DONE restarts the run, clearing done and all results as above.
- Results (err_count, fail_valid, first_fail_vec, pass) hold stable in DONE.
- S/Cout are sampled only on compare edges; other cycles are don't-care.

Optional Feature:
- Macro: FA_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the run on that compare edge.
  - FSM goes to DONE; err_count=1, fail_valid=1, pass=0.
  - The remaining vectors and passes are skipped.
- Undefined: every vector of every pass is always checked and all mismatches are counted.

Test Plan:
- Golden adder model, defaults: pulse start -> busy for 16 clocks, then done=1, pass=1, err_count=0, fail_valid=0.
- Cout stuck-at-0 model, defaults: mismatches on vectors 3,5,6,7 -> err_count=4, first_fail_vec=3'b011, pass=0.
- S inverted model, PASSES=2, ERR_W=4 -> 16 mismatches, err_count saturates at 15, first_fail_vec=3'b000.
- Assert rst during vector 4 of a run, then release -> all outputs 0, FSM in IDLE. A new start gives a clean 16-clock run with correct results.
- start pulsed again mid-run -> ignored, run completes at the original time. start pulsed in DONE -> done drops the next cycle and results clear.
- FA_BIST_STOP_ON_FAIL_EN defined, Cout stuck-at-0 -> done asserts on the compare of vector 3 (8 clocks after start), err_count=1, first_fail_vec=3'b011.
